stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised N-channel, WIDTH-bit streaming multiplexer with valid/ready handshake on every input and on the output.
- Extends the plain 2:1 bus mux with a registered output stage, two arbitration modes (fixed select, round-robin) and packet locking on a per-beat last flag.
- Sits between multiple datapath producers (ALU/memory result streams) and a single shared consumer such as the register-file write port or a bus.

Parameters:
- WIDTH, 16, data bits per channel.
- N, 4, number of input channels (N >= 2).
- SELW (localparam) = clog2(N), minimum 1; width of sel and out_chan.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  arbitration mode: 0 = fixed select, 1 = round-robin.
- sel  input  SELW  channel index used in fixed mode.
- in_valid  input  N  per-channel beat valid.
- in_last  input  N  per-channel last beat of packet.
- in_data  input  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_ready  output  N  per-channel accept; combinational.
- out_valid  output  1  output beat valid; registered.
- out_data  output  WIDTH  output beat data; registered.
- out_last  output  1  last flag of the output beat; registered.
- out_chan  output  SELW  source channel of the output beat; registered.
- out_ready  input  1  consumer accept.
- busy  output  1  packet lock active; registered.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_last=0, out_chan=0, busy=0. Internal lock_chan=0. RR pointer ptr=N-1, so channel 0 wins first. in_ready is forced to all 0 while rst_n is low.
- Load condition: load = !out_valid || out_ready. The output register accepts a new beat whenever it is empty or being drained in the same cycle. Back-to-back beats have no bubble.
- Grant selection, evaluated combinationally each cycle:
  - busy=1: grant = lock_chan. mode and sel are ignored.
  - mode=0: grant = sel. If sel >= N there is no grant.
  - mode=1: grant = first channel with in_valid=1, searching from (ptr+1) mod N upward with wrap-around. If no channel is valid there is no grant.
- in_ready[k] = rst_n && load && grant exists && k == grant. At most one bit is high. In fixed or locked mode it may be high while in_valid[k]=0.
- Transfer occurs when in_valid[g] && in_ready[g]. On the next edge:
  - out_valid=1, out_data=beat data, out_last=in_last[g], out_chan=g.
  - If load=1 and there is no transfer while out_ready=1, out_valid goes to 0 and out_data/out_last/out_chan hold their last values.
- out_valid=1 with out_ready=0: all output registers hold stable, and in_ready is all 0.
- Latency: exactly 1 cycle from input transfer to out_valid.
- Packet lock:
  - Transfer with in_last=0: busy=1, lock_chan=g.
  - Transfer with in_last=1: busy=0.
  - A single-beat packet (last=1 on the first beat) never sets busy.
- RR pointer: ptr=g on every transfer with in_last=1, in either mode. Fairness is therefore per packet, not per beat.
- Mode or sel change mid-packet has no effect until the lock clears.
- Reset mid-packet discards the buffered beat and clears the lock. The producer must restart the packet.
- Upper in_data bits of unselected channels have no effect. X on unselected channels must not propagate to outputs.

Test Plan:
1. Reset: assert rst_n=0 with all in_valid=1111 -> out_valid=0, out_data=0, busy=0, in_ready=0000. Release with mode=1 -> first in_ready=0001.
2. Round-robin: N=4, WIDTH=16, mode=1, in_valid=1111, in_last=1111, out_ready=1, channel k data=16'hA000+k -> out_data A000,A001,A002,A003,A000 on consecutive cycles; out_chan 0,1,2,3,0.
3. Packet lock: mode=1; ch1 sends 16'h0011, 16'h0012, 16'h0013 with last on the third beat; ch2 valid throughout with 16'h0020 -> out_chan 1,1,1 then 2. busy=1 from the cycle after the first beat until the cycle after the third beat.
4. Backpressure: hold out_ready=0 for 3 cycles with out_valid=1, data 16'hBEEF -> out_data stays BEEF and in_ready=0000 throughout. Raise out_ready -> next beat appears on the following cycle, with no loss and no duplication (scoreboard compare).
5. Fixed mode: mode=0, sel=2, in_valid=1111 -> only channel 2 data appears. Change sel to 3 while ch2 is mid-packet (in_last=0) -> output stays on ch2 until its last beat, then switches to ch3.
6. Edge cases, N=3: sel=3 -> in_ready=000; out_valid drops after the current beat drains. Separately, assert rst_n mid-packet -> busy=0 and out_valid=0 asynchronously; the next grant follows reset priority (channel 0 first in round-robin).

Source files
------------

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with a registered output stage, fixed or
// round-robin arbitration, and packet locking on the per-beat last flag.

module stream_mux_rr_lane #(
    parameter int WIDTH = 16,
    parameter int SELW  = 2,
    parameter int IDX   = 0
) (
    input  logic             rst_n,
    input  logic             load,
    input  logic             gnt_vld,
    input  logic [SELW-1:0]  gnt,
    input  logic             valid,
    input  logic             last,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic             xfer,
    output logic [WIDTH-1:0] data_m,
    output logic             last_m
);
    assign ready  = rst_n && load && gnt_vld && (gnt == SELW'(IDX));
    assign xfer   = ready && valid;
    // Masking by xfer keeps unselected (possibly X) lanes off the OR tree.
    assign data_m = xfer ? data : '0;
    assign last_m = xfer & last;
endmodule

module stream_mux_rr #(
    parameter  int WIDTH = 16,
    parameter  int N     = 4,
    localparam int SELW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N-1:0]       in_valid,
    input  logic [N-1:0]       in_last,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic [SELW-1:0]    out_chan,
    input  logic               out_ready,
    output logic               busy
);
    localparam logic [SELW:0] NUM = (SELW+1)'(N);

    logic [N-1:0][WIDTH-1:0] data_a;
    logic [N-1:0][WIDTH-1:0] data_m;
    logic [N-1:0]            xfer_v;
    logic [N-1:0]            last_m;
    logic [SELW-1:0]         lock_chan;
    logic [SELW-1:0]         ptr;
    logic [SELW-1:0]         gnt;
    logic                    gnt_vld;
    logic                    load;
    logic                    xfer;
    logic [WIDTH-1:0]        mux_data;
    logic                    mux_last;
    int                      idx;

    assign data_a = in_data;
    assign load   = !out_valid || out_ready;

    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        if (busy) begin
            gnt     = lock_chan;
            gnt_vld = 1'b1;
        end else if (!mode) begin
            if ({1'b0, sel} < NUM) begin
                gnt     = sel;
                gnt_vld = 1'b1;
            end
        end else begin
            // Scan farthest-first so the nearest valid channel after ptr wins.
            for (int i = N; i >= 1; i--) begin
                idx = (int'(ptr) + i) % N;
                if (in_valid[idx]) begin
                    gnt     = SELW'(idx);
                    gnt_vld = 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
        stream_mux_rr_lane #(.WIDTH(WIDTH), .SELW(SELW), .IDX(k)) u_lane (
            .rst_n   (rst_n),
            .load    (load),
            .gnt_vld (gnt_vld),
            .gnt     (gnt),
            .valid   (in_valid[k]),
            .last    (in_last[k]),
            .data    (data_a[k]),
            .ready   (in_ready[k]),
            .xfer    (xfer_v[k]),
            .data_m  (data_m[k]),
            .last_m  (last_m[k])
        );
    end

    always_comb begin
        mux_data = '0;
        for (int k = 0; k < N; k++) mux_data = mux_data | data_m[k];
    end
    assign mux_last = |last_m;
    assign xfer     = |xfer_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_chan  <= '0;
            busy      <= 1'b0;
            lock_chan <= '0;
            ptr       <= SELW'(N-1);
        end else if (load) begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= mux_data;
                out_last  <= mux_last;
                out_chan  <= gnt;
                busy      <= !mux_last;
                if (mux_last) ptr       <= gnt;
                else          lock_chan <= gnt;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: N=4 instance for the main scenarios,
// N=3 instance for out-of-range select and mid-packet reset.

module tb_stream_mux_rr;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // N=4 instance
    logic        a_mode = 1'b0, a_out_ready = 1'b1;
    logic [1:0]  a_sel = '0;
    logic [3:0]  a_in_valid = '0, a_in_last = '0;
    logic [63:0] a_in_data = '0;
    logic [3:0]  a_in_ready;
    logic        a_out_valid, a_out_last, a_busy;
    logic [15:0] a_out_data;
    logic [1:0]  a_out_chan;

    // N=3 instance
    logic        b_mode = 1'b0, b_out_ready = 1'b1;
    logic [1:0]  b_sel = '0;
    logic [2:0]  b_in_valid = '0, b_in_last = '0;
    logic [47:0] b_in_data = '0;
    logic [2:0]  b_in_ready;
    logic        b_out_valid, b_out_last, b_busy;
    logic [15:0] b_out_data;
    logic [1:0]  b_out_chan;

    stream_mux_rr #(.WIDTH(16), .N(4)) u_a (
        .clk(clk), .rst_n(rst_n), .mode(a_mode), .sel(a_sel),
        .in_valid(a_in_valid), .in_last(a_in_last), .in_data(a_in_data),
        .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
        .out_last(a_out_last), .out_chan(a_out_chan), .out_ready(a_out_ready),
        .busy(a_busy));

    stream_mux_rr #(.WIDTH(16), .N(3)) u_b (
        .clk(clk), .rst_n(rst_n), .mode(b_mode), .sel(b_sel),
        .in_valid(b_in_valid), .in_last(b_in_last), .in_data(b_in_data),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
        .out_last(b_out_last), .out_chan(b_out_chan), .out_ready(b_out_ready),
        .busy(b_busy));

    // Accepted-beat monitor for the backpressure scenario (sampled mid-cycle).
    logic        sb_on = 1'b0;
    logic [15:0] got[$];
    always @(negedge clk)
        if (sb_on && a_out_valid && a_out_ready) got.push_back(a_out_data);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a_mode = 1'b1; a_in_valid = 4'b1111; a_in_last = 4'b1111;
        step(); step();
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", a_out_valid); end
        n_checks++; if (a_out_data !== 16'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0000", a_out_data); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", a_busy); end
        n_checks++; if (a_in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got %b exp 0000", a_in_ready); end
        n_checks++; if (a_out_chan !== 2'd0) begin n_fail++; $display("FAIL reset_chan got %0d exp 0", a_out_chan); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (a_in_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant got %b exp 0001", a_in_ready); end
        a_in_valid = 4'b0000;
        step();
    endtask

    task automatic test_round_robin();
        a_mode = 1'b1; a_in_last = 4'b1111; a_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) a_in_data[k*16 +: 16] = 16'hA000 + 16'(k);
        a_in_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== 16'hA000 + 16'(i % 4) || a_out_chan !== 2'(i % 4)) begin
                n_fail++; $display("FAIL rr_beat%0d got v=%b d=%h c=%0d exp v=1 d=%h c=%0d", i, a_out_valid, a_out_data, a_out_chan, 16'hA000 + 16'(i % 4), i % 4);
            end
        end
        a_in_valid = 4'b0000;
        step();
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain got %b exp 0", a_out_valid); end
    endtask

    task automatic test_packet_lock();
        // ptr is 0 here, so ch1 is next in line.
        a_mode = 1'b1;
        a_in_data[16 +: 16] = 16'h0011; a_in_data[32 +: 16] = 16'h0020;
        a_in_last = 4'b0100; a_in_valid = 4'b0110;
        step();
        n_checks++; if (a_out_chan !== 2'd1 || a_out_data !== 16'h0011 || a_busy !== 1'b1) begin
            n_fail++; $display("FAIL lock_beat0 got c=%0d d=%h b=%b exp c=1 d=0011 b=1", a_out_chan, a_out_data, a_busy);
        end
        n_checks++; if (a_in_ready !== 4'b0010) begin n_fail++; $display("FAIL lock_ready got %b exp 0010", a_in_ready); end
        a_in_data[16 +: 16] = 16'h0012;
        step();
        n_checks++; if (a_out_chan !== 2'd1 || a_out_data !== 16'h0012 || a_busy !== 1'b1) begin
            n_fail++; $display("FAIL lock_beat1 got c=%0d d=%h b=%b exp c=1 d=0012 b=1", a_out_chan, a_out_data, a_busy);
        end
        a_in_data[16 +: 16] = 16'h0013; a_in_last = 4'b0110;
        step();
        n_checks++; if (a_out_chan !== 2'd1 || a_out_data !== 16'h0013 || a_busy !== 1'b0 || a_out_last !== 1'b1) begin
            n_fail++; $display("FAIL lock_beat2 got c=%0d d=%h b=%b l=%b exp c=1 d=0013 b=0 l=1", a_out_chan, a_out_data, a_busy, a_out_last);
        end
        a_in_valid = 4'b0100;
        step();
        n_checks++; if (a_out_chan !== 2'd2 || a_out_data !== 16'h0020 || a_out_valid !== 1'b1) begin
            n_fail++; $display("FAIL lock_next got c=%0d d=%h v=%b exp c=2 d=0020 v=1", a_out_chan, a_out_data, a_out_valid);
        end
        a_in_valid = 4'b0000;
        step();
    endtask

    task automatic test_backpressure();
        // ptr is 2 here; only ch0 is valid.
        sb_on = 1'b1; got.delete();
        a_in_data[0 +: 16] = 16'hBEEF; a_in_last = 4'b1111; a_in_valid = 4'b0001; a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0; a_in_data[0 +: 16] = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== 16'hBEEF || a_in_ready !== 4'b0000) begin
                n_fail++; $display("FAIL bp_hold%0d got v=%b d=%h r=%b exp v=1 d=beef r=0000", i, a_out_valid, a_out_data, a_in_ready);
            end
        end
        a_out_ready = 1'b1;
        step();
        n_checks++; if (a_out_data !== 16'h1234 || a_out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_release got v=%b d=%h exp v=1 d=1234", a_out_valid, a_out_data);
        end
        a_in_valid = 4'b0000;
        step();
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b exp 0", a_out_valid); end
        step();
        sb_on = 1'b0;
        n_checks++; if (got.size() != 2) begin n_fail++; $display("FAIL bp_count got %0d exp 2", got.size()); end
        else begin
            n_checks++; if (got[0] !== 16'hBEEF || got[1] !== 16'h1234) begin
                n_fail++; $display("FAIL bp_order got %h,%h exp beef,1234", got[0], got[1]);
            end
        end
    endtask

    task automatic test_fixed();
        a_mode = 1'b0; a_sel = 2'd2; a_in_last = 4'b1111; a_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) a_in_data[k*16 +: 16] = 16'hC000 + 16'(k);
        a_in_valid = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++; if (a_out_chan !== 2'd2 || a_out_data !== 16'hC002) begin
                n_fail++; $display("FAIL fixed_beat%0d got c=%0d d=%h exp c=2 d=c002", i, a_out_chan, a_out_data);
            end
        end
        a_in_last = 4'b1011;
        step();
        n_checks++; if (a_busy !== 1'b1 || a_out_chan !== 2'd2) begin
            n_fail++; $display("FAIL fixed_lock got b=%b c=%0d exp b=1 c=2", a_busy, a_out_chan);
        end
        a_sel = 2'd3;
        #1;
        n_checks++; if (a_in_ready !== 4'b0100) begin n_fail++; $display("FAIL fixed_sel_ignored got %b exp 0100", a_in_ready); end
        step();
        n_checks++; if (a_out_chan !== 2'd2 || a_busy !== 1'b1) begin
            n_fail++; $display("FAIL fixed_mid got c=%0d b=%b exp c=2 b=1", a_out_chan, a_busy);
        end
        a_in_last = 4'b1111;
        step();
        n_checks++; if (a_out_chan !== 2'd2 || a_busy !== 1'b0) begin
            n_fail++; $display("FAIL fixed_last got c=%0d b=%b exp c=2 b=0", a_out_chan, a_busy);
        end
        step();
        n_checks++; if (a_out_chan !== 2'd3 || a_out_data !== 16'hC003) begin
            n_fail++; $display("FAIL fixed_switch got c=%0d d=%h exp c=3 d=c003", a_out_chan, a_out_data);
        end
        a_in_valid = 4'b0000;
        step();
    endtask

    task automatic test_edge_n3();
        b_mode = 1'b0; b_sel = 2'd1; b_in_last = 3'b111; b_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) b_in_data[k*16 +: 16] = 16'hD000 + 16'(k);
        b_in_valid = 3'b111;
        step();
        n_checks++; if (b_out_chan !== 2'd1 || b_out_data !== 16'hD001) begin
            n_fail++; $display("FAIL n3_fixed got c=%0d d=%h exp c=1 d=d001", b_out_chan, b_out_data);
        end
        b_sel = 2'd3;
        #1;
        n_checks++; if (b_in_ready !== 3'b000) begin n_fail++; $display("FAIL n3_sel_oob got %b exp 000", b_in_ready); end
        step();
        n_checks++; if (b_out_valid !== 1'b0 || b_out_data !== 16'hD001 || b_out_chan !== 2'd1) begin
            n_fail++; $display("FAIL n3_drop got v=%b d=%h c=%0d exp v=0 d=d001 c=1", b_out_valid, b_out_data, b_out_chan);
        end
        // ptr=1 now, so round-robin picks ch2 and locks it.
        b_mode = 1'b1; b_in_last = 3'b000;
        step();
        n_checks++; if (b_out_chan !== 2'd2 || b_busy !== 1'b1) begin
            n_fail++; $display("FAIL n3_pkt got c=%0d b=%b exp c=2 b=1", b_out_chan, b_busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (b_busy !== 1'b0 || b_out_valid !== 1'b0 || b_in_ready !== 3'b000) begin
            n_fail++; $display("FAIL n3_async_rst got b=%b v=%b r=%b exp b=0 v=0 r=000", b_busy, b_out_valid, b_in_ready);
        end
        #2 rst_n = 1'b1;
        #1;
        n_checks++; if (b_in_ready !== 3'b001) begin n_fail++; $display("FAIL n3_rst_prio got %b exp 001", b_in_ready); end
        step();
        n_checks++; if (b_out_chan !== 2'd0 || b_out_data !== 16'hD000 || b_out_valid !== 1'b1) begin
            n_fail++; $display("FAIL n3_restart got c=%0d d=%h v=%b exp c=0 d=d000 v=1", b_out_chan, b_out_data, b_out_valid);
        end
        b_in_valid = 3'b000;
        step();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_fixed();
        test_edge_n3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end
endmodule
